branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001: Parameter ENTRIES, default 16, sets the number of table entries (power of two, at least 4).
REQ-002: Parameter PC_W, default 32, sets the PC and target width in bits.
REQ-003: clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004: reset, input, 1, synchronous active-low reset, sampled on the rising clock edge.
REQ-005: fetch_pc, input, PC_W, PC of the instruction in the fetch stage.
REQ-006: update_valid, input, 1, a resolved conditional branch retires this cycle.
REQ-007: update_pc, input, PC_W, PC of the resolved branch.
REQ-008: update_taken, input, 1, actual branch outcome (1 = taken).
REQ-009: update_target, input, PC_W, actual taken-target of the resolved branch.
REQ-010: update_predicted, input, 1, prediction_bit that was issued for this branch at fetch.
REQ-011: prediction_bit, output, 1, predict taken; drives datapath prediction_bit.
REQ-012: BHT_pc, output, PC_W, predicted next fetch PC; drives datapath BHT_pc.
REQ-013: branch_count, output, 16, saturating count of resolved branches.
REQ-014: mispredict_count, output, 16, saturating count of mispredicted branches.

Function
REQ-015: Index = pc[log2(ENTRIES)+1:2]; tag = pc[PC_W-1:log2(ENTRIES)+2]; pc[1:0] ignored.
REQ-016: Each entry holds valid (1b), tag, a 2-bit saturating counter, and target (PC_W).
REQ-017: Lookup is combinational, zero latency: hit = valid[idx(fetch_pc)] && tag match.
REQ-018: prediction_bit = hit && counter[1].
REQ-019: BHT_pc = stored target when prediction_bit = 1; otherwise fetch_pc+4, truncated to PC_W (wraps, e.g. FFFFFFFC -> 00000000).
REQ-020: On a rising edge with update_valid = 1, if the entry at idx(update_pc) is valid and its tag matches, the counter increments on taken and decrements on not-taken, saturating at 11 and 00.
REQ-021: On update with a hit and update_taken = 1, the target is overwritten with update_target; on not-taken, the target is unchanged.
REQ-022: On update with a miss (invalid or tag mismatch), the entry is allocated: valid = 1, tag written, counter = 10 if taken else 01, target = update_target.
REQ-023: An update writes exactly one entry; all other entries hold.
REQ-024: When a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents (no bypass).
REQ-025: branch_count increments by 1 on each update_valid cycle and saturates at FFFF.
REQ-026: mispredict_count increments by 1 when update_valid && (update_taken != update_predicted), and saturates at FFFF.
REQ-027: update_valid = 0 leaves all state and counters unchanged.

Reset
REQ-028: When reset = 0 at a rising edge, all valid bits clear, all counters set to 01, all targets set to 0, and branch_count and mispredict_count set to 0.
REQ-029: Reset has priority over a simultaneous update; the update is dropped.
REQ-030: During and after reset, prediction_bit = 0 and BHT_pc = fetch_pc+4 until the first allocation.
REQ-031: Asserting reset in the middle of a sequence of updates discards all learned state on that edge.

Verification
REQ-032: Reset, then fetch_pc = 00000040 -> prediction_bit = 0, BHT_pc = 00000044, both counts = 0.
REQ-033: Update pc 00000040, taken, target 00000100, predicted 0 -> next cycle fetch 00000040 gives prediction_bit = 1, BHT_pc = 00000100, branch_count = 1, mispredict_count = 1.
REQ-034: Three further not-taken updates at 00000040 -> counter walks 10 -> 01 -> 00 -> 00; prediction_bit = 0 after the first update; BHT_pc = 00000044.
REQ-035: Entry allocated for 00000040, then update pc 00000440 (same index, different tag; not-taken) -> entry replaced, counter = 01; fetch 00000040 misses and predicts not-taken.
REQ-036: Same-cycle update and fetch at 00000080, with the entry allocated taken -> current-cycle output reflects the old state; the following cycle reflects the new state.
REQ-037: 65540 updates with update_taken != update_predicted -> both counts hold at FFFF; reset = 0 with update_valid = 1 -> both counts = 0 and no entry allocated.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational fetch-side lookup; one-entry write per resolved branch.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            update_valid,
  input  logic [PC_W-1:0] update_pc,
  input  logic            update_taken,
  input  logic [PC_W-1:0] update_target,
  input  logic            update_predicted,
  output logic            prediction_bit,
  output logic [PC_W-1:0] BHT_pc,
  output logic [15:0]     branch_count,
  output logic [15:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  ctr_t              r_ctr    [ENTRIES];
  logic [PC_W-1:0]   r_target [ENTRIES];
  logic [15:0]       r_branch_count;
  logic [15:0]       r_mispredict_count;

  // Fetch-side address split; the byte offset plays no part in indexing.
  logic [TAG_W-1:0]  w_ftag;
  logic [IDX_W-1:0]  w_fidx;
  logic [1:0]        w_unused_fbyte;
  logic              w_fhit;
  logic              w_fpredict;
  logic [PC_W-1:0]   w_fseq_pc;

  assign {w_ftag, w_fidx, w_unused_fbyte} = fetch_pc;
  assign w_fhit     = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_fpredict = w_fhit && r_ctr[w_fidx][1];
  assign w_fseq_pc  = fetch_pc + PC_W'(4);

  assign prediction_bit = w_fpredict;
  assign BHT_pc         = w_fpredict ? r_target[w_fidx] : w_fseq_pc;

  // Update-side address split and entry state.
  logic [TAG_W-1:0]  w_utag;
  logic [IDX_W-1:0]  w_uidx;
  logic [1:0]        w_unused_ubyte;
  logic              w_uhit;
  logic              w_mispredict;
  ctr_t              w_next_ctr;
  logic [PC_W-1:0]   w_next_target;

  assign {w_utag, w_uidx, w_unused_ubyte} = update_pc;
  assign w_uhit       = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_mispredict = update_taken != update_predicted;

  always_comb begin
    w_next_ctr    = r_ctr[w_uidx];
    w_next_target = r_target[w_uidx];
    if (!w_uhit) begin
      // Fresh allocation starts weakly biased toward the observed outcome.
      w_next_ctr    = update_taken ? CTR_WT : CTR_WNT;
      w_next_target = update_target;
    end else if (update_taken) begin
      w_next_target = update_target;
      unique case (r_ctr[w_uidx])
        CTR_SNT: w_next_ctr = CTR_WNT;
        CTR_WNT: w_next_ctr = CTR_WT;
        CTR_WT:  w_next_ctr = CTR_ST;
        CTR_ST:  w_next_ctr = CTR_ST;
        default: w_next_ctr = CTR_WNT;
      endcase
    end else begin
      unique case (r_ctr[w_uidx])
        CTR_ST:  w_next_ctr = CTR_WT;
        CTR_WT:  w_next_ctr = CTR_WNT;
        CTR_WNT: w_next_ctr = CTR_SNT;
        CTR_SNT: w_next_ctr = CTR_SNT;
        default: w_next_ctr = CTR_WNT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[IDX_W'(i)]  <= 1'b0;
        r_tag[IDX_W'(i)]    <= '0;
        r_ctr[IDX_W'(i)]    <= CTR_WNT;
        r_target[IDX_W'(i)] <= '0;
      end
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (update_valid) begin
      r_valid[w_uidx]  <= 1'b1;
      r_tag[w_uidx]    <= w_utag;
      r_ctr[w_uidx]    <= w_next_ctr;
      r_target[w_uidx] <= w_next_target;
      if (r_branch_count != '1)
        r_branch_count <= r_branch_count + 16'd1;
      if (w_mispredict && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + 16'd1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
